pattern_detector: RTL and testbench
===================================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8, match-counter width, legal range 1..16.
REQ-003 Parameter RST_PAT, default 4'b1001 (PAT_W bits), pattern in force after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  qualifies `in`; no bit is consumed when low.
REQ-007 in  input  1  serial data bit.
REQ-008 pat_load  input  1  one-cycle strobe to capture pat_in.
REQ-009 pat_in  input  PAT_W  new pattern; MSB is the first bit expected on the line.
REQ-010 overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 det  output  1  Mealy match flag, combinational from state plus current in/in_valid.
REQ-013 det_q  output  1  det registered, one cycle later.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-015 Holds pattern register pat[PAT_W-1:0], history register hist[PAT_W-2:0] (newest bit at LSB), and fill counter fill (0..PAT_W-1).
REQ-016 FSM states: FILL (fill < PAT_W-1) and ARMED (fill == PAT_W-1); state is derived from fill.
REQ-017 det = in_valid & ARMED & ({hist,in} == pat) & ~pat_load, in the same cycle as the completing bit (zero latency).
REQ-018 Valid bit with no match: hist shifts left taking in; fill increments, saturating at PAT_W-1.
REQ-019 Match with overlap_en=1: hist shifts as in REQ-018; fill stays PAT_W-1, so the pattern's suffix can seed the next match.
REQ-020 Match with overlap_en=0: hist shifts, fill clears to 0; the next match needs PAT_W fresh bits.
REQ-021 in_valid=0: hist, fill and match_cnt hold; det=0.
REQ-022 pat_load=1: pat<=pat_in, hist<=0, fill<=0; a concurrent valid bit is discarded and det=0 (load wins).
REQ-023 overlap_en is sampled per bit; a change takes effect on the next match.
REQ-024 match_cnt increments on each det; it saturates at 2^CNT_W-1 and never wraps.
REQ-025 cnt_clr=1 sets match_cnt to 0; a coincident det is not counted (clear wins).
REQ-026 det_q <= det every cycle.

Reset
REQ-027 On rst low, immediately: pat=RST_PAT, hist=0, fill=0, match_cnt=0, det_q=0; det is 0 while in reset.
REQ-028 Deassertion mid-stream resumes in FILL; no bit received before reset contributes to a match.

Structure
REQ-029 A shared package pattern_detector_pkg holds the PAT_W/CNT_W legal-range constants and a fill-width function (clog2 of PAT_W).
REQ-030 One sub-module, sat_counter (CNT_W, inc, clr with clear priority), implements match_cnt; the remaining logic is flat.

Verification
REQ-031 Default parameters, overlap_en=1, stream 1001001 -> det on bits 4 and 7, match_cnt=2, det_q one cycle after each det.
REQ-032 Same stream, overlap_en=0 -> det on bit 4 only, match_cnt=1.
REQ-033 Stream 100, then pat_load with pat_in=0110 alongside bit 1, then 1 -> no det; then 0110 -> det on its last bit.
REQ-034 CNT_W=2, five matches of 1001 -> match_cnt sticks at 3; cnt_clr coincident with the 6th match -> match_cnt=0.
REQ-035 Stream 100, rst pulsed low between bits (mid-cycle, async), then 1 -> no det; all outputs 0 during reset; pat back to 1001.
REQ-036 Stream 1 0 0 with in_valid low for 3 cycles before the final 1 -> det on the final 1; state holds during the gaps.

Source files
------------

// File: rtl/pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_detector_pkg
//  Description : Shared constants, state type and sizing helper for the
//                serial pattern detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package pattern_detector_pkg;

  localparam int c_pat_w_min = 2;
  localparam int c_pat_w_max = 16;
  localparam int c_cnt_w_min = 1;
  localparam int c_cnt_w_max = 16;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } pd_state_e;

  // Fill counter spans 0..pat_w-1, so clog2(pat_w) bits suffice.
  function automatic int fill_width(input int pat_w);
    return (pat_w <= 1) ? 1 : $clog2(pat_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_detector_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear (clear wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] c_max = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_detector
//  Description : Serial bit-pattern detector with loadable pattern, optional
//                overlapping detection and a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 4'b1001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             det,
  output logic             det_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                c_fill_w   = fill_width(PAT_W);
  localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(PAT_W - 1);

  if ((PAT_W < c_pat_w_min) || (PAT_W > c_pat_w_max) ||
      (CNT_W < c_cnt_w_min) || (CNT_W > c_cnt_w_max)) begin : g_bad_params
    $error("pattern_detector: PAT_W or CNT_W outside legal range");
  end

  logic [PAT_W-1:0]    r_pat;
  logic [PAT_W-2:0]    r_hist;
  logic [c_fill_w-1:0] r_fill;
  logic                r_det_q;

  pd_state_e           w_state;
  logic [PAT_W-1:0]    w_word;
  logic                w_match;
  logic [PAT_W-1:0]    w_pat_nxt;
  logic [PAT_W-2:0]    w_hist_nxt;
  logic [c_fill_w-1:0] w_fill_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat   <= RST_PAT;
      r_hist  <= '0;
      r_fill  <= '0;
      r_det_q <= 1'b0;
    end else begin
      r_pat   <= w_pat_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_det_q <= w_match;
    end
  end

  always_comb begin
    w_state    = (r_fill == c_fill_max) ? ST_ARMED : ST_FILL;
    w_word     = {r_hist, in};
    w_match    = rst & in_valid & ~pat_load & (w_state == ST_ARMED) &
                 (w_word == r_pat);
    w_pat_nxt  = r_pat;
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;

    if (pat_load) begin
      // A bit arriving with a pattern load is dropped; history restarts.
      w_pat_nxt  = pat_in;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (in_valid) begin
      w_hist_nxt = w_word[PAT_W-2:0];
      unique case (w_state)
        ST_FILL:  w_fill_nxt = r_fill + c_fill_w'(1);
        ST_ARMED: if (w_match && !overlap_en) w_fill_nxt = '0;
        default:  w_fill_nxt = r_fill;
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_match),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

  assign det   = w_match;
  assign det_q = r_det_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_detector
//  Description : Directed self-checking bench for pattern_detector against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_detector;

  localparam int PAT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in = 1'b0;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic             overlap_en = 1'b1;
  logic             cnt_clr = 1'b0;
  logic             det, det_q, det2, det_q2;
  logic [7:0]       match_cnt;
  logic [1:0]       match_cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pattern_detector #(.PAT_W(PAT_W), .CNT_W(8), .RST_PAT(4'b1001)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .pat_load(pat_load),
    .pat_in(pat_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .det(det), .det_q(det_q), .match_cnt(match_cnt)
  );

  pattern_detector #(.PAT_W(PAT_W), .CNT_W(2), .RST_PAT(4'b1001)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .pat_load(pat_load),
    .pat_in(pat_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .det(det2), .det_q(det_q2), .match_cnt(match_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers only the bits seen since the last restart.
  bit         q[$];
  logic [3:0] m_pat = 4'b1001;
  int         m_cnt = 0;
  int         m_cnt2 = 0;
  bit         m_detq = 0;

  function automatic bit m_det_now();
    logic [PAT_W-1:0] w;
    if (!rst || !in_valid || pat_load) return 0;
    if (q.size() < PAT_W - 1) return 0;
    for (int i = 0; i < PAT_W - 1; i++)
      w[PAT_W-1-i] = q[q.size() - (PAT_W - 1) + i];
    w[0] = in;
    return w == m_pat;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit d;
    if (!rst) begin
      q.delete();
      m_pat = 4'b1001; m_cnt = 0; m_cnt2 = 0; m_detq = 0;
    end else begin
      d = m_det_now();
      m_detq = d;
      if (cnt_clr) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (d) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
      if (pat_load) begin
        m_pat = pat_in;
        q.delete();
      end else if (in_valid) begin
        if (d && !overlap_en) q.delete();
        else begin
          q.push_back(in);
          while (q.size() > PAT_W - 1) void'(q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("det", 32'(det), 32'(m_det_now()));
    chk("det_q", 32'(det_q), 32'(m_detq));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("match_cnt_w2", 32'(match_cnt2), 32'(m_cnt2));
  end

  task automatic send(input logic b, input logic v, input logic clr = 1'b0);
    @(posedge clk); #1;
    in = b; in_valid = v; pat_load = 1'b0; cnt_clr = clr;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic send_stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], 1'b1);
  endtask

  initial begin
    #2;
    chk("reset_det", 32'(det), 0);
    chk("reset_det_q", 32'(det_q), 0);
    chk("reset_cnt", 32'(match_cnt), 0);
    @(posedge clk); #1; rst = 1'b1;

    // Overlapping: 1001001 -> det on bits 4 and 7
    overlap_en = 1'b1;
    send_stream(16'b100, 3);
    send(1, 1); chk("ovl_bit4_det", 32'(det), 1);
    send(0, 1); chk("ovl_bit5_det", 32'(det), 0);
    chk("ovl_bit5_detq", 32'(det_q), 1);
    send(0, 1);
    send(1, 1); chk("ovl_bit7_det", 32'(det), 1);
    send(0, 0); chk("ovl_detq", 32'(det_q), 1);
    chk("ovl_cnt", 32'(match_cnt), 2);

    // Non-overlapping: same stream -> only bit 4
    do_reset();
    overlap_en = 1'b0;
    send_stream(16'b100, 3);
    send(1, 1); chk("novl_bit4_det", 32'(det), 1);
    send(0, 1); send(0, 1);
    send(1, 1); chk("novl_bit7_det", 32'(det), 0);
    send(0, 0); chk("novl_cnt", 32'(match_cnt), 1);
    overlap_en = 1'b1;

    // Pattern load alongside a bit discards it
    do_reset();
    send_stream(16'b100, 3);
    @(posedge clk); #1;
    in = 1'b1; in_valid = 1'b1; pat_load = 1'b1; pat_in = 4'b0110;
    @(negedge clk); #1;
    chk("load_det", 32'(det), 0);
    send(1, 1); chk("after_load_det", 32'(det), 0);
    send(0, 1); send(1, 1); send(1, 1);
    send(0, 1); chk("new_pat_det", 32'(det), 1);

    // Async reset pulse mid-stream
    send_stream(16'b100, 3);
    send(0, 0);
    rst = 1'b0; #1;
    chk("inrst_det", 32'(det), 0);
    chk("inrst_det_q", 32'(det_q), 0);
    chk("inrst_cnt", 32'(match_cnt), 0);
    #1 rst = 1'b1;
    send(1, 1); chk("post_rst_det", 32'(det), 0);
    send(0, 1); send(0, 1);
    send(1, 1); chk("rst_pat_det", 32'(det), 1);

    // Gaps: invalid cycles carry a 1 that must be ignored
    do_reset();
    send_stream(16'b100, 3);
    send(1, 0); send(1, 0); send(1, 0);
    send(1, 1); chk("gap_det", 32'(det), 1);

    // Saturation on a 2-bit counter, then clear beats a match
    do_reset();
    send_stream(16'b1001001001001001, 16);
    send(0, 0);
    chk("sat_cnt2", 32'(match_cnt2), 3);
    chk("sat_cnt8", 32'(match_cnt), 5);
    send(0, 1); send(0, 1);
    send(1, 1, 1'b1); chk("clr_match_det", 32'(det2), 1);
    send(0, 0);
    chk("clr_cnt2", 32'(match_cnt2), 0);
    chk("clr_cnt8", 32'(match_cnt), 0);

    send(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
